// File: rtl/uart_pkg.sv
// Shared UART baud-generation constants and types.
// The fractional divisor logic is enabled by defining UART_BAUD_FRAC_EN.
package uart_pkg;

    localparam int unsigned DEF_DIV_W      = 16;
    localparam int unsigned DEF_FRAC_W     = 4;
    localparam int unsigned DEF_OVERSAMPLE = 16;

    // Smallest usable integer divisor; lower programmed values are clamped to this.
    localparam int unsigned MIN_DIV = 2;

    typedef struct packed {
        logic [DEF_DIV_W-1:0]  whole;
        logic [DEF_FRAC_W-1:0] frac;
    } div_pair_t;

    // Divisor pairs for 16x oversampling from a 50 MHz clock: 50e6 / (rate * 16).
    localparam div_pair_t BAUD_2400_50M   = '{whole: 16'd1302, frac: 4'd1};
    localparam div_pair_t BAUD_4800_50M   = '{whole: 16'd651,  frac: 4'd1};
    localparam div_pair_t BAUD_9600_50M   = '{whole: 16'd325,  frac: 4'd8};
    localparam div_pair_t BAUD_19200_50M  = '{whole: 16'd162,  frac: 4'd12};
    localparam div_pair_t BAUD_115200_50M = '{whole: 16'd27,   frac: 4'd2};

endpackage

// File: rtl/uart_frac_acc.sv
// Fractional phase accumulator: the carry out of each tick's addition
// lengthens the following oversample period by one clock.
// Used only when UART_BAUD_FRAC_EN is defined.
module uart_frac_acc #(
    parameter int unsigned FRAC_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic              clear,
    input  logic [FRAC_W-1:0] frac,
    output logic              extend
);

    logic [FRAC_W-1:0] acc;

    // Accumulate the fractional divisor once per tick; clear wins over tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            extend <= 1'b0;
            acc    <= '0;
        end else if (clear) begin
            extend <= 1'b0;
            acc    <= '0;
        end else if (tick) begin
            {extend, acc} <= {1'b0, acc} + {1'b0, frac};
        end
    end

endmodule

// File: rtl/uart_baud_gen_frac.sv
// Runtime-programmable UART baud tick generator with shadowed divisor,
// enable gating and RX re-synchronisation. All outputs are clk-domain strobes.
// Macro UART_BAUD_FRAC_EN compiles in the fractional divisor; without it
// div_frac is ignored and the period is always the (clamped) integer divisor.
module uart_baud_gen_frac
    import uart_pkg::*;
#(
    parameter int unsigned DIV_W      = DEF_DIV_W,
    parameter int unsigned FRAC_W     = DEF_FRAC_W,
    parameter int unsigned OVERSAMPLE = DEF_OVERSAMPLE
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          div_wr,
    input  logic [DIV_W-1:0]              div_int,
    input  logic [FRAC_W-1:0]             div_frac,
    input  logic                          sync_restart,
    output logic                          os_tick,
    output logic                          mid_tick,
    output logic                          bit_tick,
    output logic [$clog2(OVERSAMPLE)-1:0] os_phase
);

    localparam int unsigned     OS_W    = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0] OS_MID  = OS_W'(OVERSAMPLE / 2 - 1);

    logic [DIV_W-1:0] sh_int;
    logic [DIV_W-1:0] act_int;
    logic [DIV_W-1:0] eff_int;
    logic [DIV_W-1:0] last;
    logic [DIV_W-1:0] cnt;
    logic [OS_W-1:0]  os_cnt;
    logic             extend;
    logic             hold;
    logic             tick;
    logic             load_act;

    // Counters are held cleared while disabled or being realigned.
    assign hold     = !enable || sync_restart;
    assign eff_int  = (act_int < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : act_int;
    // eff_int >= 2 so P-1 = eff_int-1+extend never wraps.
    assign last     = eff_int - DIV_W'(1) + DIV_W'(extend);
    assign tick     = !hold && (cnt == last);
    // Active divisor only changes at a period boundary, so a running period keeps its length.
    assign load_act = hold || tick;
    assign os_phase = os_cnt;

    // Shadow captures writes; active takes the shadow (or a coincident write) at load points.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sh_int  <= '0;
            act_int <= '0;
        end else begin
            if (div_wr) begin
                sh_int <= div_int;
            end
            if (load_act) begin
                act_int <= div_wr ? div_int : sh_int;
            end
        end
    end

`ifdef UART_BAUD_FRAC_EN
    logic [FRAC_W-1:0] sh_frac;
    logic [FRAC_W-1:0] act_frac;

    // Fractional half of the shadow/active divisor pair, loaded alongside the integer half.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sh_frac  <= '0;
            act_frac <= '0;
        end else begin
            if (div_wr) begin
                sh_frac <= div_frac;
            end
            if (load_act) begin
                act_frac <= div_wr ? div_frac : sh_frac;
            end
        end
    end

    uart_frac_acc #(
        .FRAC_W(FRAC_W)
    ) u_frac_acc (
        .clk   (clk),
        .reset (reset),
        .tick  (tick),
        .clear (hold),
        .frac  (act_frac),
        .extend(extend)
    );
`else
    logic frac_unused;

    assign frac_unused = ^div_frac;
    assign extend      = 1'b0;
`endif

    // Cycle counter and oversample index; os_cnt wraps naturally as OVERSAMPLE is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt    <= '0;
            os_cnt <= '0;
        end else if (hold) begin
            cnt    <= '0;
            os_cnt <= '0;
        end else if (tick) begin
            cnt    <= '0;
            os_cnt <= os_cnt + OS_W'(1);
        end else begin
            cnt    <= cnt + DIV_W'(1);
        end
    end

    // Registered single-cycle strobes decoded from the pre-increment oversample index.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            os_tick  <= 1'b0;
            mid_tick <= 1'b0;
            bit_tick <= 1'b0;
        end else begin
            os_tick  <= tick;
            mid_tick <= tick && (os_cnt == OS_MID);
            bit_tick <= tick && (os_cnt == OS_LAST);
        end
    end

endmodule
